// File: rtl/inst_fetch_unit_if.sv
// Fetch unit bus bundle: instruction memory side and core side.
// master = fetch unit, slave = memory/core environment.
interface inst_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic [31:0] pc_plus4;
  logic        inst_misaligned;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    input  redirect, redirect_pc,
    output inst_valid,
    input  inst_ready,
    output inst_out, inst_pc, pc_plus4,
    output inst_misaligned
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    output redirect, redirect_pc,
    input  inst_valid,
    output inst_ready,
    input  inst_out, inst_pc, pc_plus4,
    input  inst_misaligned
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// Decoupled instruction fetch stage with prefetch FIFO and redirect flush.
// Optional IFU_ALIGN_CHECK_EN: misaligned redirect halts fetch, sets flag.
module inst_fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic clk,
  input logic rst,
  inst_fetch_unit_if.master bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

`ifdef IFU_ALIGN_CHECK_EN
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HALT} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_WAIT} state_e;
`endif

  state_e        state_q, state_d;
  logic          req_q, req_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          discard_q, discard_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   pcs_q  [DEPTH];

  logic        ack, push, pop, space, bad;
  logic [31:0] rpc;

`ifdef IFU_ALIGN_CHECK_EN
  logic mis_q, mis_d;
  assign rpc = bus.redirect_pc;
  assign bad = |bus.redirect_pc[1:0];
`else
  assign rpc = bus.redirect_pc & ~32'd3;
  assign bad = 1'b0;
`endif

  assign ack   = req_q & bus.imem_ack;
  assign push  = ack & ~discard_q & ~bus.redirect;
  assign pop   = (cnt_q != '0) & bus.inst_ready & ~bus.redirect;
  assign space = cnt_d < CW'(DEPTH);

  always_comb begin
    cnt_d = cnt_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    if (bus.redirect) begin
      cnt_d = '0;
      rd_d  = '0;
      wr_d  = '0;
    end else begin
      cnt_d = cnt_q + CW'(push) - CW'(pop);
      if (push) wr_d = wr_q + PW'(1);
      if (pop)  rd_d = rd_q + PW'(1);
    end
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (bus.redirect)  fetch_pc_d = rpc;
    else if (push)     fetch_pc_d = addr_q + 32'd4;
  end

  // a redirect with a request still in flight poisons its ack
  always_comb begin
    discard_d = discard_q;
    if (bus.redirect && req_q && !bus.imem_ack) discard_d = 1'b1;
    else if (ack)                                 discard_d = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    unique case (state_q)
      S_IDLE: begin
        if (!bus.redirect && space) begin
          state_d = S_WAIT;
          req_d   = 1'b1;
          addr_d  = fetch_pc_q;
        end
      end
      S_WAIT: begin
        if (ack) begin
          if (space) begin
            addr_d = fetch_pc_d;
          end else begin
            state_d = S_IDLE;
            req_d   = 1'b0;
          end
        end
      end
`ifdef IFU_ALIGN_CHECK_EN
      S_HALT: begin
        if (ack) req_d = 1'b0;
        if (bus.redirect && !bad) begin
          if (req_q && !bus.imem_ack) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_IDLE;
            req_d   = 1'b0;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
`ifdef IFU_ALIGN_CHECK_EN
    if (bus.redirect && bad) begin
      state_d = S_HALT;
      req_d   = req_q & ~bus.imem_ack;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      discard_q  <= 1'b0;
      cnt_q      <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      fetch_pc_q <= fetch_pc_d;
      discard_q  <= discard_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      data_q[wr_q] <= bus.imem_rdata;
      pcs_q[wr_q]  <= addr_q;
    end
  end

`ifdef IFU_ALIGN_CHECK_EN
  assign mis_d = bus.redirect ? bad : mis_q;

  always_ff @(posedge clk) begin
    if (rst) mis_q <= 1'b0;
    else     mis_q <= mis_d;
  end

  assign bus.inst_misaligned = mis_q;
`else
  assign bus.inst_misaligned = 1'b0;
`endif

  assign bus.imem_req   = req_q;
  assign bus.imem_addr  = addr_q;
  assign bus.inst_valid = cnt_q != '0;
  assign bus.inst_out   = data_q[rd_q];
  assign bus.inst_pc    = pcs_q[rd_q];
  assign bus.pc_plus4   = pcs_q[rd_q] + 32'd4;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: vector table, directed
// corner sequences and a random run against an instruction-stream model.
module tb_inst_fetch_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inst_fetch_unit_if bus();

  inst_fetch_unit #(
    .DEPTH(4),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;
  int lat = 0;
  bit rnd_ack = 1'b0;
  int wcnt = 0;
  int fires = 0;

  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    logic        ready;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vt [8];

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_5A5A;
  endfunction

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", n, act, exp);
    end
  endtask

  task automatic timeout(input string n);
    tests++;
    fails++;
    $display("FAIL %s: timed out waiting for DUT", n);
  endtask

  // memory model: ack after lat wait cycles, or random acks
  task automatic tick();
    logic fire, preq;
    fire = bus.imem_req & bus.imem_ack;
    preq = bus.imem_req;
    if (fire === 1'b1 && !rst) fires++;
    @(posedge clk);
    #1;
    if (preq !== 1'b1 || fire === 1'b1) wcnt = 0;
    else wcnt++;
    if (rnd_ack)
      bus.imem_ack = bus.imem_req & ($urandom_range(3) != 0);
    else
      bus.imem_ack = bus.imem_req & (wcnt >= lat);
    bus.imem_rdata = word(bus.imem_addr);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    bus.inst_ready = 1'b0;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = '0;
    tick();
    tick();
    chk("rst_req", 32'(bus.imem_req), 0);
    chk("rst_valid", 32'(bus.inst_valid), 0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_mis", 32'(bus.inst_misaligned), 0);
    rst = 1'b0;
  endtask

  task automatic chk_head(input string n, input logic [31:0] pc);
    chk({n, "_pc"}, bus.inst_pc, pc);
    chk({n, "_out"}, bus.inst_out, word(pc));
    chk({n, "_p4"}, bus.pc_plus4, pc + 32'd4);
  endtask

  initial begin
    int n;
    bit stayed;
    logic r, rd;
    logic [31:0] tgt, exp_pc, paddr;
    logic preq, pack;
    int pops;

    vt[0] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         1'b0, 32'h0};
    vt[1] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h4,         1'b1, 32'h0};
    vt[2] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h8,         1'b1, 32'h4};
    vt[3] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'hC,         1'b1, 32'h8};
    vt[4] = '{1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0};
    vt[5] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFF8};
    vt[6] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         1'b1, 32'hFFFF_FFFC};
    vt[7] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h4,         1'b1, 32'h0};

    // zero-wait streaming then redirect near the 2^32 wrap
    lat = 0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      bus.redirect = vt[i].redir;
      bus.redirect_pc = vt[i].rpc;
      bus.inst_ready = vt[i].ready;
      tick();
      chk($sformatf("vec%0d_req", i), 32'(bus.imem_req), 32'(vt[i].exp_req));
      if (vt[i].exp_req)
        chk($sformatf("vec%0d_addr", i), bus.imem_addr, vt[i].exp_addr);
      chk($sformatf("vec%0d_valid", i), 32'(bus.inst_valid),
          32'(vt[i].exp_valid));
      if (vt[i].exp_valid)
        chk_head($sformatf("vec%0d", i), vt[i].exp_pc);
    end
    bus.redirect = 1'b0;

    // fill with core stalled, 1-wait memory
    lat = 1;
    do_reset();
    fires = 0;
    for (int i = 0; i < 12; i++) tick();
    chk("fill_pushes", 32'(fires), 4);
    chk("fill_req", 32'(bus.imem_req), 0);
    chk("fill_valid", 32'(bus.inst_valid), 1);
    chk_head("fill_head", 32'h0);
    stayed = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.imem_req !== 1'b0) stayed = 1'b0;
    end
    chk("fill_req_stays_low", 32'(stayed), 1);
    chk("fill_no_extra_push", 32'(fires), 4);
    bus.inst_ready = 1'b1;
    tick();
    bus.inst_ready = 1'b0;
    chk("pop_req", 32'(bus.imem_req), 1);
    chk("pop_addr", bus.imem_addr, 32'h10);
    chk_head("pop_head", 32'h4);

    // redirect while a slow request is outstanding
    lat = 3;
    do_reset();
    bus.inst_ready = 1'b1;
    n = 0;
    while (!(bus.imem_req === 1'b1 && bus.imem_addr === 32'h8) && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) timeout("slow_find_req8");
    tick();
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h100;
    tick();
    bus.redirect = 1'b0;
    chk("slow_held_req", 32'(bus.imem_req), 1);
    chk("slow_held_addr", bus.imem_addr, 32'h8);
    chk("slow_flush", 32'(bus.inst_valid), 0);
    n = 0;
    while (bus.imem_addr === 32'h8 && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) timeout("slow_addr_change");
    chk("slow_new_req", 32'(bus.imem_req), 1);
    chk("slow_new_addr", bus.imem_addr, 32'h100);
    n = 0;
    while (bus.inst_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) timeout("slow_first_valid");
    chk_head("slow_first", 32'h100);

    // redirect coincident with ack
    lat = 0;
    do_reset();
    bus.inst_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("same_pre_ack", 32'(bus.imem_ack), 1);
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h400;
    tick();
    bus.redirect = 1'b0;
    chk("same_flush", 32'(bus.inst_valid), 0);
    chk("same_req", 32'(bus.imem_req), 1);
    chk("same_addr", bus.imem_addr, 32'h400);
    tick();
    chk("same_valid", 32'(bus.inst_valid), 1);
    chk_head("same_head", 32'h400);

`ifdef IFU_ALIGN_CHECK_EN
    do_reset();
    bus.inst_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h102;
    tick();
    bus.redirect = 1'b0;
    chk("mis_set", 32'(bus.inst_misaligned), 1);
    chk("mis_flush", 32'(bus.inst_valid), 0);
    stayed = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.imem_req !== 1'b0) stayed = 1'b0;
    end
    chk("mis_halt_no_req", 32'(stayed), 1);
    chk("mis_sticky", 32'(bus.inst_misaligned), 1);
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h200;
    tick();
    bus.redirect = 1'b0;
    chk("mis_clear", 32'(bus.inst_misaligned), 0);
    n = 0;
    while (bus.inst_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) timeout("mis_resume");
    chk_head("mis_resume", 32'h200);
`else
    do_reset();
    bus.inst_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h102;
    tick();
    bus.redirect = 1'b0;
    chk("mask_mis", 32'(bus.inst_misaligned), 0);
    chk("mask_addr", bus.imem_addr, 32'h100);
    tick();
    chk_head("mask_head", 32'h100);
`endif

    // random traffic against an in-order instruction-stream model
    lat = 0;
    do_reset();
    rnd_ack = 1'b1;
    exp_pc = 32'h0;
    pops = 0;
    for (int c = 0; c < 3000; c++) begin
      r = ($urandom_range(19) == 0);
      tgt = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(3) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hC);
      rd = 1'($urandom_range(1));
      bus.redirect = r;
      bus.redirect_pc = tgt;
      bus.inst_ready = rd;
      if (bus.inst_valid === 1'b1 && rd && !r) begin
        chk_head("rnd", exp_pc);
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      if (r) exp_pc = tgt;
      preq = bus.imem_req;
      pack = bus.imem_ack;
      paddr = bus.imem_addr;
      tick();
      if (preq && !pack) begin
        chk("rnd_req_held", 32'(bus.imem_req), 1);
        chk("rnd_addr_held", bus.imem_addr, paddr);
      end
      if (r) chk("rnd_flush", 32'(bus.inst_valid), 0);
    end
    bus.redirect = 1'b0;
    rnd_ack = 1'b0;
    chk("rnd_progress", 32'(pops > 200), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far",
             fails);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
Decoupled instruction fetch stage upstream of the single-cycle datapath's decoder and register file. Issues req/ack fetches to a multi-cycle instruction memory and buffers returned words in a small prefetch FIFO. Presents instruction, PC and PC+4 to the core with a valid/ready handshake. Branch/jump redirects flush the FIFO and restart fetch at the target.

Parameters:
DEPTH, 4, prefetch FIFO entries; power of two, at least 2
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
imem_req  output  1  fetch request to instruction memory; registered
imem_addr  output  32  word address of the outstanding request; registered
imem_ack  input  1  memory returns data this cycle; sampled only while imem_req=1
imem_rdata  input  32  instruction word; valid when imem_req&imem_ack
redirect  input  1  branch taken or jump; flush and refetch
redirect_pc  input  32  redirect target
inst_valid  output  1  inst_out/inst_pc hold a valid FIFO head
inst_ready  input  1  core consumes the head this cycle
inst_out  output  32  head instruction word
inst_pc  output  32  PC of the head instruction
pc_plus4  output  32  inst_pc+4, modulo 2^32
inst_misaligned  output  1  sticky misaligned-target flag; constant 0 without the optional feature

Behaviour:
- Reset (rst=1 at an edge): FIFO empty; inst_valid=0; imem_req=0; imem_addr=RESET_PC; fetch_pc=RESET_PC; discard=0; inst_misaligned=0. When rst is high it overrides every other input.
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: imem_req=1, waiting for imem_ack.
  - HALT: exists only with the optional feature.
- IDLE->WAIT at an edge when (count - pop + 0) < DEPTH. On that edge, imem_addr<=fetch_pc. The first request is therefore visible one cycle after rst deasserts.
- While in WAIT, imem_req and imem_addr are held stable until the ack edge. At most one request is outstanding.
- Ack edge (imem_req & imem_ack):
  - If discard=0 and redirect=0: push {imem_rdata, imem_addr} and set fetch_pc<=imem_addr+4.
  - If space remains after the push and pop, stay in WAIT with imem_addr<=imem_addr+4 (back-to-back; peak 1 instruction per cycle with zero-wait memory). Otherwise go to IDLE.
- Zero-wait memory is allowed: ack may be high in the same cycle req first rises.
- Pop: occurs at an edge where inst_valid & inst_ready & !redirect. inst_valid rises the cycle after the first push into an empty FIFO; there is no bypass.
- Simultaneous push and pop while full: legal; count is unchanged.
- FIFO full: no new request is issued, and an outstanding request completes normally. The space check counts that in-flight request, so an overflow cannot occur.
- Empty: inst_valid=0. inst_out/inst_pc hold their last value and are don't-care.
- Redirect edge:
  - FIFO is flushed (count<=0, so inst_valid=0 the next cycle); no pop occurs; fetch_pc<=redirect_pc.
  - If WAIT without ack this cycle: set discard=1. The request stays held; its ack data is dropped and discard clears. Then a new request for fetch_pc is issued.
  - If the ack arrives in the same cycle as the redirect: data is dropped, and the next request uses redirect_pc.
  - If IDLE: the request for redirect_pc issues on the following edge.
- A second redirect while discard=1 updates fetch_pc only; discard stays 1.
- fetch_pc and pc_plus4 wrap modulo 2^32: 32'hFFFF_FFFC+4 = 32'h0.
- Without the optional feature, redirect_pc[1:0] is forced to 2'b00.

Optional Feature:
IFU_ALIGN_CHECK_EN
- Defined:
  - A redirect with redirect_pc[1:0]!=0 sets inst_misaligned=1 (sticky), flushes the FIFO and enters HALT.
  - HALT issues no requests. Any outstanding ack is still consumed and discarded.
  - HALT exits only on a redirect with an aligned target (this clears inst_misaligned) or on rst.
- Undefined: inst_misaligned is tied 0, there is no HALT state, and the low bits are masked.

Test Plan:
1. Reset, then zero-wait memory (ack=req) with inst_ready=1 -> imem_addr sequence 0,4,8,C; inst_valid high from the 3rd cycle after rst falls; inst_pc 0,4,8 on consecutive cycles; pc_plus4=inst_pc+4.
2. inst_ready=0 with a 1-wait memory -> exactly 4 entries are pushed, then imem_req=0 and stays 0. Raising inst_ready for one cycle pops PC 0 and re-issues a request for addr 0x10.
3. 3-cycle memory latency, redirect to 0x100 in the 2nd wait cycle of the request for 0x8 -> req/addr 0x8 held until ack, data dropped, next imem_addr=0x100, and the first valid inst_pc=0x100.
4. Redirect and imem_ack in the same cycle with inst_ready=1 -> no pop, acked word absent from the FIFO, next request at redirect_pc.
5. Redirect to 0xFFFF_FFF8 with zero-wait memory -> inst_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000; pc_plus4 of FFFF_FFFC is 0.
6. (IFU_ALIGN_CHECK_EN) Redirect to 0x102 -> inst_misaligned=1, imem_req=0 for 10 cycles. Then redirect to 0x200 -> inst_misaligned=0, and fetch resumes at 0x200.
